// File: rtl/booth_pkg.sv
// ============================================================================
// booth_pkg : shared widths, FSM state and Booth-select types
// Rev 1.0
// ============================================================================
`default_nettype none

package booth_pkg;

  localparam int W    = 24;
  localparam int PPW  = W + 2;
  localparam int NDIG = (W + 3) / 3;
  localparam int AW   = 2 * W + 4;
  localparam int YW   = 3 * NDIG + 1;
  localparam int CW   = 4;
  localparam int SW   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // sel is one-hot over the magnitudes 0/1/2/3/4 (bit index = multiple)
  typedef struct packed {
    logic       neg;
    logic [4:0] sel;
  } booth_sel_t;

endpackage

`default_nettype wire

// File: rtl/booth_r8_seq_mult_enc.sv
// ============================================================================
// booth_r8_enc : radix-8 Booth digit encoder, 4-bit group to sign + one-hot
// Rev 1.0
// ============================================================================
`default_nettype none

module booth_r8_enc
  import booth_pkg::*;
(
  input  logic [3:0] i_grp,
  output booth_sel_t o_sel
);

  always_comb begin
    o_sel     = '0;
    o_sel.sel = 5'b00001;
    case (i_grp)
      4'b0000, 4'b1111: o_sel.sel = 5'b00001;
      4'b0001, 4'b0010: o_sel.sel = 5'b00010;
      4'b0011, 4'b0100: o_sel.sel = 5'b00100;
      4'b0101, 4'b0110: o_sel.sel = 5'b01000;
      4'b0111:          o_sel.sel = 5'b10000;
      4'b1000: begin
        o_sel.neg = 1'b1;
        o_sel.sel = 5'b10000;
      end
      4'b1001, 4'b1010: begin
        o_sel.neg = 1'b1;
        o_sel.sel = 5'b01000;
      end
      4'b1011, 4'b1100: begin
        o_sel.neg = 1'b1;
        o_sel.sel = 5'b00100;
      end
      4'b1101, 4'b1110: begin
        o_sel.neg = 1'b1;
        o_sel.sel = 5'b00010;
      end
      default: o_sel.sel = 5'b00001;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/booth_r8_seq_mult.sv
// ============================================================================
// booth_r8_seq_mult : iterative radix-8 Booth multiplier, one digit per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module booth_r8_seq_mult
  import booth_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PPW-1:0]   x1,
  input  logic [PPW-1:0]   x2,
  input  logic [PPW-1:0]   x3,
  input  logic [PPW-1:0]   x4,
  input  logic [W-1:0]     y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   product,
  output logic             busy
);

  state_t                r_state;
  state_t                w_next;
  logic [PPW-1:0]        r_x1;
  logic [PPW-1:0]        r_x2;
  logic [PPW-1:0]        r_x3;
  logic [PPW-1:0]        r_x4;
  logic [YW-1:0]         r_yext;
  logic [CW-1:0]         r_cnt;
  logic signed [AW-1:0]  r_acc;

  booth_sel_t            w_sel;
  logic [PPW:0]          w_mag;
  logic [PPW:0]          w_pp;
  logic signed [AW-1:0]  w_pp_ext;
  logic signed [AW-1:0]  w_pp_sh;
  logic [SW-1:0]         w_shamt;
  logic                  w_last;

  // r_yext shifts right 3 per digit, so the current group is always its low nibble
  booth_r8_enc u_enc (
    .i_grp (r_yext[3:0]),
    .o_sel (w_sel)
  );

  always_comb begin
    w_mag = '0;
    case (1'b1)
      w_sel.sel[0]: w_mag = '0;
      w_sel.sel[1]: w_mag = {1'b0, r_x1};
      w_sel.sel[2]: w_mag = {1'b0, r_x2};
      w_sel.sel[3]: w_mag = {1'b0, r_x3};
      w_sel.sel[4]: w_mag = {1'b0, r_x4};
      default:      w_mag = '0;
    endcase
  end

  assign w_pp     = w_sel.neg ? -w_mag : w_mag;
  assign w_pp_ext = {{(AW-PPW-1){w_pp[PPW]}}, w_pp};
  assign w_shamt  = {r_cnt, 1'b0} + SW'(r_cnt);
  assign w_pp_sh  = w_pp_ext <<< w_shamt;
  assign w_last   = (r_cnt == CW'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x1   <= '0;
      r_x2   <= '0;
      r_x3   <= '0;
      r_x4   <= '0;
      r_yext <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x1   <= x1;
            r_x2   <= x2;
            r_x3   <= x3;
            r_x4   <= x4;
            r_yext <= {3'b000, y, 1'b0};
            r_cnt  <= '0;
            r_acc  <= '0;
          end
        end
        BUSY: begin
          r_acc  <= r_acc + w_pp_sh;
          r_cnt  <= r_cnt + CW'(1);
          r_yext <= r_yext >> 3;
        end
        default: ;
      endcase
    end
  end

  assign product = r_acc[2*W-1:0];

endmodule

`default_nettype wire
